// File: rtl/rsa_sched.sv
// -----------------------------------------------------------------------------
// rsa_sched -- RSA decryption scheduler for one 8-symbol block.
//
// Collects eight ciphertext symbols and the key material (p, q, e). It drives
// p/q/e to an external key-generation IP and captures the modulus n and the
// private exponent d that the IP returns. It then decrypts each symbol with
// MSB-first square-and-multiply (m = c^d mod n) and streams the eight
// plaintext symbols back out in input order.
//
// Ports
//   clk        system clock, all state on rising edge
//   rst        asynchronous active-high reset
//   in_valid   high for 8 consecutive beats per operation
//   in_p/in_q  primes, sampled on the first beat only
//   in_e       public exponent, sampled on the first beat only
//   in_c       ciphertext symbol, one per beat
//   ip_p/ip_q  registered primes to the key IP
//   ip_e       registered public exponent to the key IP
//   ip_n/ip_d  modulus and private exponent from the key IP (combinational)
//   out_valid  high for 8 consecutive cycles per operation
//   out_m      decrypted symbol, zero whenever out_valid is low
// -----------------------------------------------------------------------------
module rsa_sched #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic [WIDTH-1:0]   in_p,
   input  logic [WIDTH-1:0]   in_q,
   input  logic [2*WIDTH-1:0] in_e,
   input  logic [2*WIDTH-1:0] in_c,
   output logic [WIDTH-1:0]   ip_p,
   output logic [WIDTH-1:0]   ip_q,
   output logic [2*WIDTH-1:0] ip_e,
   input  logic [2*WIDTH-1:0] ip_n,
   input  logic [2*WIDTH-1:0] ip_d,
   output logic               out_valid,
   output logic [2*WIDTH-1:0] out_m
);

   localparam int EW = 2 * WIDTH;      // word width of n, d, c, m
   localparam int PW = 4 * WIDTH;      // full product width, no truncation before mod
   localparam int BW = $clog2(EW);     // exponent bit counter width

   typedef enum logic [2:0] {IDLE, LOAD, KEY, EXP, OUT} state_t;

   state_t         state, state_nx;
   logic [EW-1:0]  slot_mem [8];
   logic [2:0]     slot_cnt;           // write slot in LOAD, symbol in EXP, read slot in OUT
   logic [BW-1:0]  bit_cnt;
   logic [EW-1:0]  n_r, d_r, r_q;

   logic           last_bit;
   logic [BW-1:0]  bit_idx;
   logic [EW-1:0]  c_mod, r_base, sq_mod, r_nx;
   logic [PW-1:0]  prod_sq, prod_mul;

   // ---------------------------------------------------------------------------
   // Square-and-multiply step: r = r*r mod n, then (if bit set) r = r*c mod n,
   // both in one cycle. r restarts at 1 on the first bit of every symbol.
   // ---------------------------------------------------------------------------
   // NOTE: combinational blocks use blocking assignments and give every output
   // a default first, so no path can leave a value held and infer a latch.
   always_comb begin
      last_bit = (bit_cnt == BW'(EW - 1));
      bit_idx  = BW'(EW - 1) - bit_cnt;
      c_mod    = EW'(PW'(slot_mem[slot_cnt]) % PW'(n_r));
      r_base   = (bit_cnt == '0) ? EW'(1) : r_q;
      prod_sq  = PW'(r_base) * PW'(r_base);
      sq_mod   = EW'(prod_sq % PW'(n_r));
      prod_mul = PW'(sq_mod) * PW'(c_mod);
      r_nx     = d_r[bit_idx] ? EW'(prod_mul % PW'(n_r)) : sq_mod;
   end

   // ---------------------------------------------------------------------------
   // FSM: state register + next-state / output decode.
   // ---------------------------------------------------------------------------
   // NOTE: sequential state is written with non-blocking assignments so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      out_valid = 1'b0;
      out_m     = '0;
      unique case (state)
         IDLE: if (in_valid) state_nx = LOAD;
         LOAD: if (in_valid && slot_cnt == 3'd7) state_nx = KEY;
         KEY:  state_nx = EXP;
         EXP:  if (last_bit && slot_cnt == 3'd7) state_nx = OUT;
         OUT: begin
            out_valid = 1'b1;
            out_m     = slot_mem[slot_cnt];
            if (slot_cnt == 3'd7) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Datapath registers. in_valid only has an effect in IDLE and LOAD.
   // ---------------------------------------------------------------------------
   // NOTE: the symbol buffer is reset along with the other state so that an
   // aborted operation can never leak old plaintext onto out_m.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ip_p     <= '0;
         ip_q     <= '0;
         ip_e     <= '0;
         n_r      <= '0;
         d_r      <= '0;
         r_q      <= '0;
         slot_cnt <= '0;
         bit_cnt  <= '0;
         for (int i = 0; i < 8; i++) slot_mem[i] <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  ip_p        <= in_p;
                  ip_q        <= in_q;
                  ip_e        <= in_e;
                  slot_mem[0] <= in_c;
                  slot_cnt    <= 3'd1;
               end
            end
            LOAD: begin
               if (in_valid) begin
                  slot_mem[slot_cnt] <= in_c;
                  slot_cnt           <= slot_cnt + 3'd1;   // wraps to 0 after slot 7
               end
            end
            KEY: begin
               n_r     <= ip_n;
               d_r     <= ip_d;
               bit_cnt <= '0;
            end
            EXP: begin
               r_q <= r_nx;
               if (last_bit) begin
                  slot_mem[slot_cnt] <= r_nx;
                  slot_cnt           <= slot_cnt + 3'd1;   // wraps to 0 for OUT
                  bit_cnt            <= '0;
               end else begin
                  bit_cnt <= bit_cnt + BW'(1);
               end
            end
            OUT: slot_cnt <= slot_cnt + 3'd1;              // wraps to 0 for next load
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rsa_sched.sv
// -----------------------------------------------------------------------------
// tb_rsa_sched -- self-checking bench for rsa_sched (WIDTH = 4).
// Contains a behavioural key-generation IP (n = p*q, d = e^-1 mod (p-1)(q-1)).
// Expected plaintext is queued as each ciphertext beat is driven and popped as
// the DUT presents each output beat.
// -----------------------------------------------------------------------------
module tb_rsa_sched;

   localparam int W  = 4;
   localparam int LAT = 16 * W + 2;

   logic           clk = 1'b0;
   logic           rst;
   logic           in_valid;
   logic [W-1:0]   in_p, in_q;
   logic [2*W-1:0] in_e, in_c;
   logic [W-1:0]   ip_p, ip_q;
   logic [2*W-1:0] ip_e, ip_n, ip_d;
   logic           out_valid;
   logic [2*W-1:0] out_m;

   int checks = 0;
   int errors = 0;
   logic [2*W-1:0] exp_q [$];

   rsa_sched #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid),
      .in_p(in_p), .in_q(in_q), .in_e(in_e), .in_c(in_c),
      .ip_p(ip_p), .ip_q(ip_q), .ip_e(ip_e),
      .ip_n(ip_n), .ip_d(ip_d),
      .out_valid(out_valid), .out_m(out_m)
   );

   always #5 clk = ~clk;

   // Key-generation IP model.
   function automatic logic [2*W-1:0] inv_mod(input logic [2*W-1:0] e, input int phi);
      for (int d = 0; d < 256; d++)
         if (phi > 0 && ((int'(e) * d) % phi) == 1) return 8'(d);
      return '0;
   endfunction

   always_comb begin
      ip_n = 8'(ip_p * ip_q);
      ip_d = inv_mod(ip_e, (int'(ip_p) - 1) * (int'(ip_q) - 1));
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One operation: 8 input beats, wait for output, compare 8 output beats.
   // abort_at > 0 pulses rst that many cycles after the last input beat.
   task automatic run_op(input logic [W-1:0] p, input logic [W-1:0] q,
                         input logic [2*W-1:0] e,
                         input logic [2*W-1:0] c [8], input logic [2*W-1:0] m [8],
                         input bit toggle, input int abort_at);
      bit stable = 1'b1;
      int k = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (i == 0) begin
            check("idle_valid", out_valid, 0);
            check("idle_m", out_m, 0);
            in_p = p; in_q = q; in_e = e;
         end else begin
            if (ip_p !== p || ip_q !== q || ip_e !== e) stable = 1'b0;
            in_p = 4'($urandom); in_q = 4'($urandom); in_e = 8'($urandom);
         end
         in_valid = 1'b1;
         in_c     = c[i];
         exp_q.push_back(m[i]);
      end
      for (k = 1; k <= 300; k++) begin
         @(negedge clk);
         if (out_valid) break;
         if (ip_p !== p || ip_q !== q || ip_e !== e) stable = 1'b0;
         if (!toggle && out_m !== '0) stable = 1'b0;
         if (k == abort_at) begin
            rst = 1'b1;
            #1;
            check("abort_valid", out_valid, 0);
            check("abort_ip", {ip_p, ip_q, ip_e}, 0);
            @(negedge clk);
            rst      = 1'b0;
            in_valid = 1'b0;
            exp_q.delete();
            return;
         end
         in_valid = toggle ? k[0] : 1'b0;
         in_c     = 8'($urandom);
         in_p     = 4'($urandom);
      end
      check("latency", k, LAT);
      for (int j = 0; j < 8; j++) begin
         if (j > 0) @(negedge clk);
         check("out_valid_hi", out_valid, 1);
         if (ip_p !== p || ip_q !== q || ip_e !== e) stable = 1'b0;
         if (exp_q.size() > 0) check($sformatf("out_m[%0d]", j), out_m, exp_q.pop_front());
         in_valid = toggle ? j[0] : 1'b0;
         in_c     = 8'($urandom);
      end
      in_valid = 1'b0;
      check("ip_stable", stable, 1);
   endtask

   logic [2*W-1:0] c1 [8], m1 [8], c2 [8], m2 [8], c3 [8], m3 [8], c4 [8], m4 [8];
   bit quiet;

   initial begin
      c1 = '{8, 2, 0, 1, 32, 8, 2, 0};     m1 = '{2, 29, 0, 1, 32, 2, 29, 0};
      c2 = '{2, 3, 34, 1, 0, 2, 3, 34};    m2 = '{32, 33, 34, 1, 0, 32, 33, 34};
      c3 = '{0, 5, 33, 66, 1, 32, 255, 7}; m3 = '{1, 1, 1, 1, 1, 1, 1, 1};
      c4 = '{33, 66, 8, 99, 2, 0, 231, 1}; m4 = '{0, 0, 2, 0, 29, 0, 0, 1};

      rst = 1'b1; in_valid = 1'b0; in_p = '0; in_q = '0; in_e = '0; in_c = '0;
      repeat (3) @(negedge clk);
      check("rst_valid", out_valid, 0);
      check("rst_m", out_m, 0);
      check("rst_ip", {ip_p, ip_q, ip_e}, 0);

      // First beat lands on the first rising edge after reset release.
      @(posedge clk); #1 rst = 1'b0;
      run_op(3, 11, 3, c1, m1, 1'b0, 0);

      // Back-to-back: next operation starts the cycle after the last out_valid.
      run_op(5, 7, 5, c2, m2, 1'b0, 0);

      // in_valid noise during KEY/EXP/OUT must not disturb anything.
      repeat (3) @(negedge clk);
      run_op(3, 11, 3, c1, m1, 1'b1, 0);

      // Reset during EXP aborts; the following operation alone appears.
      repeat (2) @(negedge clk);
      run_op(3, 11, 3, c1, m1, 1'b0, 30);
      run_op(5, 7, 5, c2, m2, 1'b0, 0);

      // d = 0 gives 1 everywhere; c mod n = 0 with d != 0 gives 0.
      run_op(3, 11, 0, c3, m3, 1'b0, 0);
      run_op(3, 11, 3, c4, m4, 1'b0, 0);

      quiet = 1'b1;
      repeat (50) begin
         @(negedge clk);
         if (out_valid !== 1'b0 || out_m !== '0) quiet = 1'b0;
      end
      check("quiet_after", quiet, 1);
      check("queue_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
